// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
// slave is the loader side, master is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  MemWrEn;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [31:0]           MemData;

  modport master (
    output ByteIn, ByteValid,
    input  ByteReady,
    input  MemWrEn, MemAddr, MemData
  );

  modport slave (
    input  ByteIn, ByteValid,
    output ByteReady,
    output MemWrEn, MemAddr, MemData
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles big-endian words from a byte
// stream, writes them at consecutive word addresses and holds the CPU meanwhile.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 Start,
  input  logic [LEN_WIDTH-1:0] Length,
  imem_loader_if.slave         bus,
  output logic                 CpuHold,
  output logic                 Done,
  output logic                 Error,
  output logic [31:0]          Checksum
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam int                   IDX_W   = ADDR_WIDTH - 2;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_WORDS);

  logic [2:0]            state;
  logic [1:0]            byte_cnt;
  logic [IDX_W-1:0]      word_idx;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [23:0]           shift_q;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;

  logic byte_xfer;
  logic last_word;

  assign bus.ByteReady = (state == S_RECV);
  assign bus.MemWrEn   = wr_en;
  assign bus.MemAddr   = addr_q;
  assign bus.MemData   = data_q;

  assign byte_xfer = bus.ByteValid && (state == S_RECV);
  assign last_word = (LEN_WIDTH'(word_idx) + LEN_WIDTH'(1)) == len_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      word_idx <= '0;
      len_q    <= '0;
      shift_q  <= '0;
      wr_en    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      CpuHold  <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      Checksum <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (Start) begin
            Done     <= 1'b0;
            Error    <= 1'b0;
            Checksum <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            len_q    <= Length;
            if (Length > MAX_LEN) begin
              state <= S_ERROR;
              Error <= 1'b1;
            end else if (Length == '0) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state   <= S_RECV;
              CpuHold <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (byte_xfer) begin
            shift_q  <= {shift_q[15:0], bus.ByteIn};
            byte_cnt <= byte_cnt + 2'd1;
            // Fourth byte goes straight into the write register, so the
            // write strobe lines up with the single WRITE cycle.
            if (byte_cnt == 2'd3) begin
              state  <= S_WRITE;
              wr_en  <= 1'b1;
              addr_q <= {word_idx, 2'b00};
              data_q <= {shift_q, bus.ByteIn};
            end
          end
        end

        S_WRITE: begin
          Checksum <= Checksum ^ data_q;
          if (last_word) begin
            state   <= S_DONE;
            Done    <= 1'b1;
            CpuHold <= 1'b0;
          end else begin
            word_idx <= word_idx + IDX_W'(1);
            state    <= S_RECV;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of directed loads, multi-cycle corner sequences,
// and randomized loads checked against a queue-based reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [8:0]  Length = '0;
  logic        CpuHold, Done, Error;
  logic [31:0] Checksum;

  imem_loader_if #(.ADDR_WIDTH(10)) bus ();

  imem_loader #(.ADDR_WIDTH(10), .MAX_WORDS(256), .LEN_WIDTH(9)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Length(Length), .bus(bus),
    .CpuHold(CpuHold), .Done(Done), .Error(Error), .Checksum(Checksum)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_edge[$];
  int          rdy_seen = 0;
  int          rdy_on_write = 0;
  logic [7:0]  tx_q[$];

  typedef struct {
    int          len;
    logic [63:0] bytes;
    int          stall;
    logic        exp_err;
    logic        exp_done;
    int          exp_nw;
    logic [31:0] exp_ck;
    logic [31:0] exp_last;
    int          exp_lat;
  } vec_t;

  vec_t vt[7];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor: a write is captured on the edge following this sample.
  always @(negedge clk) begin
    if (bus.MemWrEn) begin
      wr_addr.push_back(bus.MemAddr);
      wr_data.push_back(bus.MemData);
      wr_edge.push_back(cyc + 1);
      if (bus.ByteReady) rdy_on_write++;
    end
    if (bus.ByteReady) rdy_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic start_load(input int len);
    Start  = 1'b1;
    Length = len[8:0];
    @(posedge clk); #1;
    start_cyc = cyc;
    Start  = 1'b0;
    Length = '0;
  endtask

  task automatic send_bytes(input int n, input int stall_mode, input int mid_start, output bit ok);
    bit acc;
    int t;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == mid_start) begin
        Start  = 1'b1;
        Length = 9'd0;
        @(posedge clk); #1;
        Start  = 1'b0;
      end
      bus.ByteValid = 1'b1;
      bus.ByteIn    = tx_q[i];
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 64) begin
        @(negedge clk);
        acc = bus.ByteReady;
        @(posedge clk); #1;
        t++;
      end
      bus.ByteValid = 1'b0;
      if (!acc) begin
        check("byte_accept_timeout", i, n);
        ok = 1'b0;
        return;
      end
      if (stall_mode == 1 && (i % 4) == 1) begin
        repeat (3) @(posedge clk);
        #1;
      end else if (stall_mode == 2) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_end(output int lat);
    lat = -1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (Done || Error) begin
        lat = cyc - start_cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Reference model: word n is bytes 4n..4n+3 big-endian at byte address 4n.
  task automatic model_check(input string tag, input int len);
    logic        err;
    int          nw;
    int          mism;
    logic [31:0] w;
    logic [31:0] ck;
    err  = (len > 256);
    nw   = err ? 0 : len;
    mism = 0;
    ck   = '0;
    for (int n = 0; n < nw; n++) begin
      w  = {tx_q[4*n], tx_q[4*n+1], tx_q[4*n+2], tx_q[4*n+3]};
      ck = ck ^ w;
      if (n < wr_data.size())
        if (wr_data[n] !== w || wr_addr[n] !== 10'(n * 4)) mism++;
    end
    check({tag, " nwrites"}, wr_data.size(), nw);
    check({tag, " write_mismatches"}, mism, 0);
    check({tag, " checksum"}, Checksum, ck);
    check({tag, " done"}, Done, !err);
    check({tag, " error"}, Error, err);
    check({tag, " cpuhold_end"}, CpuHold, 1'b0);
    check({tag, " ready_on_write"}, rdy_on_write, 0);
    if (nw == 0) check({tag, " ready_never"}, rdy_seen, 0);
  endtask

  task automatic do_load(input string tag, input int len, input int stall_mode,
                         input int mid_start, output int lat);
    bit ok;
    wr_addr.delete();
    wr_data.delete();
    wr_edge.delete();
    rdy_seen     = 0;
    rdy_on_write = 0;
    start_load(len);
    if (len > 0 && len <= 256) begin
      check({tag, " cpuhold_start"}, CpuHold, 1'b1);
      send_bytes(len * 4, stall_mode, mid_start, ok);
    end else begin
      check({tag, " cpuhold_start"}, CpuHold, 1'b0);
    end
    wait_end(lat);
    model_check(tag, len);
  endtask

  logic [63:0] v;
  int          lat;
  int          len;
  int          ms;
  bit          ok;

  initial begin
    vt[0] = '{len: 2,   bytes: 64'h8C010004_AC220008, stall: 0, exp_err: 0, exp_done: 1,
              exp_nw: 2, exp_ck: 32'h2023000C, exp_last: 32'hAC220008, exp_lat: 10};
    vt[1] = '{len: 2,   bytes: 64'h8C010004_AC220008, stall: 1, exp_err: 0, exp_done: 1,
              exp_nw: 2, exp_ck: 32'h2023000C, exp_last: 32'hAC220008, exp_lat: -1};
    vt[2] = '{len: 300, bytes: 64'h0,                 stall: 0, exp_err: 1, exp_done: 0,
              exp_nw: 0, exp_ck: 32'h0,        exp_last: 32'h0,        exp_lat: 0};
    vt[3] = '{len: 1,   bytes: 64'h0,                 stall: 0, exp_err: 0, exp_done: 1,
              exp_nw: 1, exp_ck: 32'h0,        exp_last: 32'h0,        exp_lat: 5};
    vt[4] = '{len: 0,   bytes: 64'h0,                 stall: 0, exp_err: 0, exp_done: 1,
              exp_nw: 0, exp_ck: 32'h0,        exp_last: 32'h0,        exp_lat: 0};
    vt[5] = '{len: 1,   bytes: 64'hDEADBEEF_00000000, stall: 0, exp_err: 0, exp_done: 1,
              exp_nw: 1, exp_ck: 32'hDEADBEEF, exp_last: 32'hDEADBEEF, exp_lat: 5};
    vt[6] = '{len: 257, bytes: 64'h0,                 stall: 0, exp_err: 1, exp_done: 0,
              exp_nw: 0, exp_ck: 32'h0,        exp_last: 32'h0,        exp_lat: 0};

    bus.ByteValid = 1'b0;
    bus.ByteIn    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ctrl", {CpuHold, Done, Error, bus.MemWrEn, bus.ByteReady}, 5'b0);
    check("reset addr", bus.MemAddr, 10'd0);
    check("reset data", bus.MemData, 32'd0);
    check("reset checksum", Checksum, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      tx_q.delete();
      v = vt[k].bytes;
      for (int b = 0; b < 8; b++) tx_q.push_back(v[63-8*b -: 8]);
      do_load($sformatf("vec%0d", k), vt[k].len, vt[k].stall, -1, lat);
      check($sformatf("vec%0d tbl_done", k), Done, vt[k].exp_done);
      check($sformatf("vec%0d tbl_error", k), Error, vt[k].exp_err);
      check($sformatf("vec%0d tbl_nwrites", k), wr_data.size(), vt[k].exp_nw);
      check($sformatf("vec%0d tbl_checksum", k), Checksum, vt[k].exp_ck);
      if (vt[k].exp_nw > 0)
        check($sformatf("vec%0d tbl_last", k),
              (wr_data.size() > 0) ? wr_data[wr_data.size()-1] : 32'hxxxxxxxx, vt[k].exp_last);
      if (vt[k].exp_lat >= 0)
        check($sformatf("vec%0d done_latency", k), lat, vt[k].exp_lat);
      if (k == 0) begin
        check("vec0 write1_cycle", (wr_edge.size() > 0) ? wr_edge[0] - start_cyc : -1, 5);
        check("vec0 write2_cycle", (wr_edge.size() > 1) ? wr_edge[1] - start_cyc : -1, 10);
      end
    end

    // Full-size load: word n is byte n replicated.
    tx_q.delete();
    for (int n = 0; n < 256; n++)
      for (int b = 0; b < 4; b++) tx_q.push_back(8'(n));
    do_load("full", 256, 0, -1, lat);
    check("full last_addr", (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : 10'h0, 10'd1020);
    check("full last_data", (wr_data.size() > 0) ? wr_data[wr_data.size()-1] : 32'h0, 32'hFFFFFFFF);
    check("full checksum_zero", Checksum, 32'h0);

    // Reset mid-load after the 6th byte.
    tx_q.delete();
    for (int b = 0; b < 16; b++) tx_q.push_back(8'($urandom));
    wr_addr.delete();
    wr_data.delete();
    wr_edge.delete();
    start_load(4);
    send_bytes(6, 0, -1, ok);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("abort ctrl", {CpuHold, Done, Error, bus.MemWrEn, bus.ByteReady}, 5'b0);
    check("abort addr", bus.MemAddr, 10'd0);
    check("abort data", bus.MemData, 32'd0);
    check("abort checksum", Checksum, 32'd0);
    check("abort nwrites", wr_data.size(), 1);
    check("abort word0", (wr_data.size() > 0) ? wr_data[0] : 32'h0,
          {tx_q[0], tx_q[1], tx_q[2], tx_q[3]});
    @(posedge clk); #1;

    // Start pulsed mid-RECV must be ignored.
    tx_q.delete();
    tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    tx_q.push_back(8'h56); tx_q.push_back(8'h78);
    do_load("midstart", 1, 0, 2, lat);
    check("midstart data", (wr_data.size() > 0) ? wr_data[0] : 32'h0, 32'h12345678);

    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = $urandom_range(257, 511);
        default: len = $urandom_range(1, 8);
      endcase
      tx_q.delete();
      for (int b = 0; b < len * 4 && len <= 256; b++) tx_q.push_back(8'($urandom));
      ms = ($urandom_range(0, 2) == 0 && len > 0 && len <= 256) ? $urandom_range(0, len * 4 - 1) : -1;
      do_load($sformatf("rand%0d", r), len, 2, ms, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
